conv_frame_sequencer: RTL
=========================

Name: conv_frame_sequencer

Overview:
- Frame-level controller for the 12-layer, 4-channel, 3x3 CONV_2D datapath.
- On start, it walks the input frame buffer in raster order, issues one read address per cycle, and drives the conv block's valid_in aligned to the 1-cycle buffer read latency.
- It counts the conv block's valid_out pulses against the expected output-pixel count, then signals done, or a timeout error if the datapath stalls.
- It sits between the host/control FSM, the input frame RAM and the conv block.

Parameters:
- IMG_Width, 24, input frame width in pixels
- IMG_Height, 24, input frame height in pixels
- Kernel, 3, convolution kernel size
- Stride, 1, convolution stride (1 or 2)
- ADDR_W, 10, read address width; must satisfy 2^ADDR_W >= IMG_Width*IMG_Height
- CNT_W, 16, width of the output pixel counter
- TIMEOUT, 1024, maximum idle cycles without valid_out in DRAIN

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to process one frame; accepted only in IDLE
- abort  in  1  stops the current frame; honoured in FEED and DRAIN
- rd_en  out  1  frame RAM read enable
- rd_addr  out  ADDR_W  frame RAM read address, raster order
- conv_valid_in  out  1  valid_in to the conv block; equals rd_en delayed 1 cycle
- conv_valid_out  in  1  valid_out from the conv block
- busy  out  1  high in FEED and DRAIN
- done  out  1  one-cycle pulse at frame completion, normal or timeout
- err_timeout  out  1  sticky; cleared on accepted start or rst
- err_extra  out  1  sticky; valid_out seen with out_count already at EXP; cleared on accepted start or rst
- out_count  out  CNT_W  valid_out pulses counted in the current frame; holds after done

Behaviour:
- Reset values: rd_en=0, rd_addr=0, conv_valid_in=0, busy=0, done=0, err_timeout=0, err_extra=0, out_count=0, state=IDLE. Reset mid-frame returns to IDLE the next edge, with no done pulse.
- Constants:
  - N_IN = IMG_Width*IMG_Height (576 at defaults).
  - EXP = ((IMG_Width-Kernel)/Stride+1)*((IMG_Height-Kernel)/Stride+1), integer division (484 at defaults; 121 at Stride=2).
- States IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 at edge k moves to FEED at k+1.
  - The same edge clears out_count, err_timeout, err_extra and the address counters.
- FEED:
  - rd_en=1 every cycle, no gaps.
  - rd_addr = row*IMG_Width + col, with col incrementing and wrapping at IMG_Width-1 and row incrementing on wrap.
  - The first rd_en cycle has rd_addr=0; the N_IN-th has rd_addr=N_IN-1.
  - After the last address, go to DRAIN.
- conv_valid_in is a registered copy of rd_en. It is therefore high for exactly N_IN consecutive cycles, starting one cycle after the first rd_en.
- Output counting:
  - conv_valid_out is counted in FEED and in DRAIN, since outputs appear before feeding ends.
  - out_count increments by 1 per pulse and saturates at EXP.
  - A pulse with out_count==EXP sets err_extra and does not increment.
- DRAIN:
  - rd_en=0.
  - The idle counter resets on every valid_out and increments otherwise.
  - When out_count reaches EXP (including if it already did during FEED), go to DONE.
  - When the idle counter reaches TIMEOUT, set err_timeout and go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. valid_out pulses arriving in DONE or IDLE after completion set err_extra.
- start while busy or in DONE is ignored; there is no queueing.
- abort in FEED or DRAIN:
  - Next state is IDLE and rd_en drops the next cycle.
  - conv_valid_in drops one cycle after rd_en.
  - No done pulse; out_count holds.
  - abort together with start in IDLE: start wins, abort is ignored.
- Simultaneous events on the same edge:
  - Final valid_out and timeout threshold: completion wins and err_timeout stays 0.
  - rst dominates every other input.

Test Plan:
1. Defaults, rst then start; the conv model emits 484 valid_out starting 60 cycles after the first conv_valid_in -> rd_addr runs 0..575 on 576 consecutive rd_en cycles, conv_valid_in spans 576 cycles offset by 1, done pulses once on the cycle after the 484th valid_out, out_count=484, no error flags.
2. Start pulsed again at FEED address 100 and during DONE -> ignored; address sequence unbroken; exactly one done. A subsequent start from IDLE clears out_count to 0.
3. Model emits only 100 valid_out then goes silent, TIMEOUT=1024 -> err_timeout=1 on the 1024th idle DRAIN cycle, done pulses, out_count=100; the next start clears err_timeout.
4. abort asserted when rd_addr=200 -> rd_en=0 next cycle, conv_valid_in=0 one cycle later, state IDLE, no done, out_count holds.
5. rst asserted mid-DRAIN with out_count=300 -> all outputs return to reset values next edge; a start afterwards restarts from rd_addr=0.
6. Stride=2, model emits 122 valid_out -> done after the 121st, out_count=121, err_extra=1 after the 122nd pulse.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the CONV_2D datapath: streams the input frame in raster
// order, aligns valid_in to the RAM read latency and tracks conv outputs until done.
module conv_frame_sequencer #(
    parameter int IMG_Width  = 24,
    parameter int IMG_Height = 24,
    parameter int Kernel     = 3,
    parameter int Stride     = 1,
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              conv_valid_in,
    input  logic              conv_valid_out,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_extra,
    output logic [CNT_W-1:0]  out_count
);

    localparam int OUT_W   = (IMG_Width - Kernel) / Stride + 1;
    localparam int OUT_H   = (IMG_Height - Kernel) / Stride + 1;
    localparam int EXP_INT = OUT_W * OUT_H;
    localparam int COL_W   = (IMG_Width > 1) ? $clog2(IMG_Width) : 1;
    localparam int ROW_W   = (IMG_Height > 1) ? $clog2(IMG_Height) : 1;
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  EXP        = CNT_W'(EXP_INT);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_Width - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_Height - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_q;
    logic [IDLE_W-1:0] idle_cnt;
    logic              frame_done;

    logic accept_start;
    logic in_frame;
    logic abort_hit;
    logic last_pix;
    logic counting;
    logic at_exp;
    logic count_inc;
    logic complete;
    logic idle_hit;
    logic timeout_fire;
    logic extra_hit;

    assign accept_start = (state == S_IDLE) && start;
    assign in_frame     = (state == S_FEED) || (state == S_DRAIN);
    assign abort_hit    = in_frame && abort;
    assign last_pix     = (col == COL_LAST) && (row == ROW_LAST);

    // A pulse that finds the counter already full is an overrun, never a count.
    assign counting  = in_frame && conv_valid_out;
    assign at_exp    = (out_count == EXP);
    assign count_inc = counting && !at_exp;
    assign complete  = at_exp || (count_inc && (out_count == EXP - 1'b1));

    assign idle_hit     = !conv_valid_out && (idle_cnt == IDLE_LIMIT - 1'b1);
    assign timeout_fire = (state == S_DRAIN) && !abort && !complete && idle_hit;

    assign extra_hit = conv_valid_out &&
                       ((counting && at_exp) ||
                        (state == S_DONE) ||
                        ((state == S_IDLE) && frame_done));

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_FEED;
            S_FEED: begin
                if (abort)         state_d = S_IDLE;
                else if (last_pix) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                    state_d = S_IDLE;
                else if (complete || idle_hit) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            col           <= '0;
            row           <= '0;
            addr_q        <= '0;
            idle_cnt      <= '0;
            conv_valid_in <= 1'b0;
            out_count     <= '0;
            err_timeout   <= 1'b0;
            err_extra     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_d;
            conv_valid_in <= rd_en;

            // Address counters only run inside FEED; anywhere else they sit at pixel 0.
            if ((state == S_FEED) && !abort && !last_pix) begin
                addr_q <= addr_q + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                col    <= '0;
                row    <= '0;
                addr_q <= '0;
            end

            if ((state == S_DRAIN) && !conv_valid_out) idle_cnt <= idle_cnt + 1'b1;
            else                                       idle_cnt <= '0;

            if (accept_start)   out_count <= '0;
            else if (count_inc) out_count <= out_count + 1'b1;

            if (accept_start)      err_timeout <= 1'b0;
            else if (timeout_fire) err_timeout <= 1'b1;

            if (accept_start)   err_extra <= 1'b0;
            else if (extra_hit) err_extra <= 1'b1;

            // Late outputs only count as overruns once a frame has actually completed.
            if (state == S_DONE)                 frame_done <= 1'b1;
            else if (accept_start || abort_hit) frame_done <= 1'b0;
        end
    end

    assign rd_en   = (state == S_FEED);
    assign rd_addr = addr_q;
    assign busy    = in_frame;
    assign done    = (state == S_DONE);

endmodule
